// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Fetch stage sitting directly upstream of the program counter. It reads
// variable-length instructions (1-3 bytes) from byte-wide program memory at
// the current pc. It hands each complete instruction to the decoder over a
// valid/ready handshake. It also computes the value the program counter loads
// on every clock edge: hold, sequential advance, branch target or reset vector.
//
// Instruction length comes from opcode[7:6]: 00->1, 01->2, 10->3, 11->1.
//
// Ports:
//   clk            in   system clock, all state on posedge
//   reset          in   synchronous, active-high reset
//   pc             in   current program_counter value
//   next_pc        out  value program_counter loads on the next edge
//   mem_addr       out  program memory byte address (pc + byte index, wraps)
//   mem_rd         out  read request, held stable until mem_ready
//   mem_rdata      in   read data, valid when mem_ready=1
//   mem_ready      in   read completes this cycle
//   branch_taken   in   redirect request from execute (single-cycle pulse)
//   branch_target  in   redirect address
//   instr_valid    out  instruction bundle valid
//   instr_ready    in   decoder accepts the bundle
//   instr_opcode   out  byte 0
//   instr_op1      out  byte 1 (0 if absent)
//   instr_op2      out  byte 2 (0 if absent)
//   instr_len      out  instruction length 1..3 (0 out of reset)
//   instr_pc       out  address of byte 0
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int unsigned        ADDR_W       = 16,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] next_pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr_opcode,
    output logic [7:0]        instr_op1,
    output logic [7:0]        instr_op2,
    output logic [1:0]        instr_len,
    output logic [ADDR_W-1:0] instr_pc
);

    typedef enum logic [2:0] {
        BOOT,
        FETCH_OP,
        FETCH_B1,
        FETCH_B2,
        ISSUE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [7:0]        op1_q, op1_d;
    logic [7:0]        op2_q, op2_d;
    logic [1:0]        len_q, len_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic [1:0]        byte_idx;

    function automatic logic [1:0] decode_len(input logic [7:0] opcode);
        case (opcode[7:6])
            2'b01:   decode_len = 2'd2;
            2'b10:   decode_len = 2'd3;
            default: decode_len = 2'd1;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // State and bundle registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the bundle registers are cleared on reset because they drive
            // outputs directly and must read 0 before the first fetch.
            state_q  <= BOOT;
            opcode_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            len_q    <= '0;
            ipc_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            len_q    <= len_d;
            ipc_q    <= ipc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and bundle capture
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a hold default first so no path can
        // infer a latch.
        state_d  = state_q;
        opcode_d = opcode_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        len_d    = len_q;
        ipc_d    = ipc_q;

        // A redirect wins over any in-flight read or pending issue. The
        // partial bundle is simply abandoned and overwritten by the next fetch.
        if (branch_taken && state_q != BOOT) begin
            state_d = FETCH_OP;
        end else begin
            case (state_q)
                BOOT: state_d = FETCH_OP;
                FETCH_OP: begin
                    if (mem_ready) begin
                        opcode_d = mem_rdata;
                        ipc_d    = pc;
                        op1_d    = '0;
                        op2_d    = '0;
                        len_d    = decode_len(mem_rdata);
                        state_d  = (decode_len(mem_rdata) == 2'd1) ? ISSUE : FETCH_B1;
                    end
                end
                FETCH_B1: begin
                    if (mem_ready) begin
                        op1_d   = mem_rdata;
                        state_d = (len_q == 2'd2) ? ISSUE : FETCH_B2;
                    end
                end
                FETCH_B2: begin
                    if (mem_ready) begin
                        op2_d   = mem_rdata;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (instr_ready) state_d = FETCH_OP;
                end
                default: state_d = BOOT;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        mem_rd      = 1'b0;
        byte_idx    = 2'd0;
        instr_valid = 1'b0;
        next_pc     = pc;

        case (state_q)
            FETCH_OP: mem_rd = 1'b1;
            FETCH_B1: begin
                mem_rd   = 1'b1;
                byte_idx = 2'd1;
            end
            FETCH_B2: begin
                mem_rd   = 1'b1;
                byte_idx = 2'd2;
            end
            // Suppressed during a redirect so no handshake can complete.
            ISSUE:    instr_valid = !branch_taken;
            default:  ;
        endcase

        // BOOT forces the program counter onto the reset vector whatever its
        // own reset value was.
        if (state_q == BOOT) begin
            next_pc = RESET_VECTOR;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end else if (instr_valid && instr_ready) begin
            next_pc = pc + ADDR_W'(len_q);
        end

        // Reset aborts combinationally, before the state register catches up.
        if (reset) begin
            mem_rd      = 1'b0;
            instr_valid = 1'b0;
            next_pc     = RESET_VECTOR;
        end
    end

    // Operand bytes sit at consecutive addresses, wrapping modulo 2^ADDR_W.
    assign mem_addr     = pc + ADDR_W'(byte_idx);

    assign instr_opcode = opcode_q;
    assign instr_op1    = op1_q;
    assign instr_op2    = op2_q;
    assign instr_len    = len_q;
    assign instr_pc     = ipc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Testbench for instr_fetch. It models the program counter as a register that
// loads next_pc on every edge. Program memory is a byte array with a
// programmable number of wait states. Expected bundles are queued when the
// program is laid out. A monitor pops and compares them on every accepted
// handshake.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc = 16'hDEAD;
    logic [15:0] next_pc;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_opcode;
    logic [7:0]  instr_op1;
    logic [7:0]  instr_op2;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc;

    instr_fetch #(
        .ADDR_W       (16),
        .RESET_VECTOR (16'h0100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .next_pc       (next_pc),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_opcode  (instr_opcode),
        .instr_op1     (instr_op1),
        .instr_op2     (instr_op2),
        .instr_len     (instr_len),
        .instr_pc      (instr_pc)
    );

    always #5 clk = ~clk;

    // Program counter model and cycle counter.
    int cyc = 0;
    always @(posedge clk) begin
        pc  <= next_pc;
        cyc <= cyc + 1;
    end

    // Program memory with wait_cfg wait cycles before each completed read.
    logic [7:0] mem [0:65535];
    int wait_cfg = 0;
    int wcnt     = 0;
    assign mem_ready = mem_rd && (wcnt >= wait_cfg);
    assign mem_rdata = mem_ready ? mem[mem_addr] : 8'hEE;
    always @(posedge clk) begin
        if (!mem_rd || mem_ready) wcnt <= 0;
        else                      wcnt <= wcnt + 1;
    end

    // Scoreboard
    typedef struct {
        int opcode;
        int op1;
        int op2;
        int len;
        int ipc;
    } exp_t;

    typedef struct {
        int addr;
        int b0;
        int b1;
        int b2;
        int len;
    } vec_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples the handshake 2 time units before the accepting edge.
    always begin
        @(negedge clk);
        #3;
        if (instr_valid && instr_ready) begin
            acc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_bundle: got opcode %0h pc %0h expected none",
                         instr_opcode, instr_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_opcode", 32'(instr_opcode), e.opcode);
                check("sb_op1",    32'(instr_op1),    e.op1);
                check("sb_op2",    32'(instr_op2),    e.op2);
                check("sb_len",    32'(instr_len),    e.len);
                check("sb_pc",     32'(instr_pc),     e.ipc);
            end
        end
    end

    task automatic push_exp(input int op, input int o1, input int o2, input int len, input int ipc);
        exp_t e;
        e = '{op, o1, o2, len, ipc};
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !instr_valid; i++) begin
            @(negedge clk);
            #1;
        end
        check("valid_timeout", 32'(instr_valid), 1);
    endtask

    initial begin
        vec_t vecs[5];
        int   rel;

        vecs[0] = '{'h0100, 'h05, 'h00, 'h00, 1};
        vecs[1] = '{'h0101, 'h45, 'hAA, 'h00, 2};
        vecs[2] = '{'h0103, 'h85, 'h34, 'h12, 3};
        vecs[3] = '{'h0106, 'hC7, 'h00, 'h00, 1};
        vecs[4] = '{'h0107, 'h3F, 'h00, 'h00, 1};

        reset         = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        instr_ready   = 1'b1;

        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        foreach (vecs[i]) begin
            mem[vecs[i].addr[15:0]] = vecs[i].b0[7:0];
            if (vecs[i].len > 1) mem[16'(vecs[i].addr + 1)] = vecs[i].b1[7:0];
            if (vecs[i].len > 2) mem[16'(vecs[i].addr + 2)] = vecs[i].b2[7:0];
            push_exp(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].len, vecs[i].addr);
        end
        mem[16'h0108] = 8'h4B; mem[16'h0109] = 8'h77;
        mem[16'h010A] = 8'h80; mem[16'h010B] = 8'h11; mem[16'h010C] = 8'h22;
        mem[16'h010D] = 8'h81; mem[16'h010E] = 8'h55; mem[16'h010F] = 8'h66;
        mem[16'h2000] = 8'h07;
        mem[16'hFFFF] = 8'h4C; mem[16'h0000] = 8'h5A;
        mem[16'h0001] = 8'h9C; mem[16'h0002] = 8'h01; mem[16'h0003] = 8'h02;

        // ---------------- Reset and BOOT ----------------
        #1;
        check("rst_next_pc", 32'(next_pc), 'h0100);
        check("rst_mem_rd",  32'(mem_rd), 0);
        check("rst_valid",   32'(instr_valid), 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rel   = cyc;
        #1;
        check("boot_next_pc", 32'(next_pc), 'h0100);
        check("boot_mem_rd",  32'(mem_rd), 0);
        check("boot_valid",   32'(instr_valid), 0);
        check("boot_pc",      32'(pc), 'h0100);
        check("boot_len",     32'(instr_len), 0);
        @(negedge clk);
        #1;
        check("first_mem_addr", 32'(mem_addr), 'h0100);
        check("first_mem_rd",   32'(mem_rd), 1);

        // ---------------- Table-driven sequence ----------------
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        instr_ready = 1'b0;
        check("seq_drained", exp_q.size(), 0);
        check("seq_end_pc",  32'(pc), 'h0108);
        if (acc_q.size() >= 5) begin
            check("tput_first", acc_q[0] - rel, 2);
            check("tput_len2",  acc_q[1] - acc_q[0], 3);
            check("tput_len3",  acc_q[2] - acc_q[1], 4);
            check("tput_len1a", acc_q[3] - acc_q[2], 2);
            check("tput_len1b", acc_q[4] - acc_q[3], 2);
        end else begin
            check("tput_count", acc_q.size(), 5);
        end

        // ---------------- Backpressure ----------------
        #1;
        wait_valid(20);
        for (int k = 0; k < 4; k++) begin
            check("bp_valid",   32'(instr_valid), 1);
            check("bp_opcode",  32'(instr_opcode), 'h4B);
            check("bp_op1",     32'(instr_op1), 'h77);
            check("bp_op2",     32'(instr_op2), 0);
            check("bp_len",     32'(instr_len), 2);
            check("bp_ipc",     32'(instr_pc), 'h0108);
            check("bp_next_pc", 32'(next_pc), 32'(pc));
            check("bp_pc",      32'(pc), 'h0108);
            @(negedge clk);
            #1;
        end
        push_exp('h4B, 'h77, 0, 2, 'h0108);
        instr_ready = 1'b1;
        #1;
        check("bp_accept_next_pc", 32'(next_pc), 'h010A);
        @(negedge clk);
        instr_ready = 1'b0;
        wait_cfg    = 3;
        #1;
        check("bp_after_pc",    32'(pc), 'h010A);
        check("bp_after_valid", 32'(instr_valid), 0);

        // ---------------- Wait states ----------------
        for (int k = 0; k < 12; k++) begin
            check("ws_mem_rd",   32'(mem_rd), 1);
            check("ws_mem_addr", 32'(mem_addr), 'h010A + k / 4);
            check("ws_valid",    32'(instr_valid), 0);
            @(negedge clk);
            #1;
        end
        check("ws_issue_valid", 32'(instr_valid), 1);
        check("ws_opcode",      32'(instr_opcode), 'h80);
        check("ws_op2",         32'(instr_op2), 'h22);
        push_exp('h80, 'h11, 'h22, 3, 'h010A);
        instr_ready = 1'b1;
        #1;
        check("ws_next_pc", 32'(next_pc), 'h010D);

        // ---------------- Branch during FETCH_B1 ----------------
        @(negedge clk);
        wait_cfg = 0;
        #1;
        check("br_pre_pc", 32'(pc), 'h010D);
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 16'h2000;
        #1;
        check("br_b1_mem_addr", 32'(mem_addr), 'h010E);
        check("br_b1_valid",    32'(instr_valid), 0);
        check("br_b1_next_pc",  32'(next_pc), 'h2000);
        @(negedge clk);
        branch_taken = 1'b0;
        push_exp('h07, 0, 0, 1, 'h2000);
        #1;
        check("br_b1_pc",       32'(pc), 'h2000);
        check("br_b1_new_addr", 32'(mem_addr), 'h2000);
        check("br_b1_new_rd",   32'(mem_rd), 1);

        // ---------------- Branch during ISSUE with instr_ready=1 ----------------
        @(negedge clk);
        #1;
        check("br_is_valid_pre", 32'(instr_valid), 1);
        branch_taken = 1'b1;
        #1;
        check("br_is_valid",   32'(instr_valid), 0);
        check("br_is_next_pc", 32'(next_pc), 'h2000);
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        check("br_is_pc",       32'(pc), 'h2000);
        check("br_is_mem_addr", 32'(mem_addr), 'h2000);
        check("br_is_refetch",  32'(instr_valid), 0);
        @(negedge clk);
        #1;
        check("br_re_valid",   32'(instr_valid), 1);
        check("br_re_next_pc", 32'(next_pc), 'h2001);

        // ---------------- Address wrap ----------------
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 16'hFFFF;
        push_exp('h4C, 'h5A, 0, 2, 'hFFFF);
        #1;
        check("wrap_br_next_pc", 32'(next_pc), 'hFFFF);
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        check("wrap_op_addr", 32'(mem_addr), 'hFFFF);
        @(negedge clk);
        #1;
        check("wrap_b1_addr", 32'(mem_addr), 'h0000);
        @(negedge clk);
        #1;
        check("wrap_valid",   32'(instr_valid), 1);
        check("wrap_next_pc", 32'(next_pc), 'h0001);
        @(negedge clk);
        #1;
        check("wrap_pc", 32'(pc), 'h0001);

        // ---------------- Reset in FETCH_B2 ----------------
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rb2_mem_addr", 32'(mem_addr), 'h0003);
        reset = 1'b1;
        #1;
        check("rb2_valid",   32'(instr_valid), 0);
        check("rb2_mem_rd",  32'(mem_rd), 0);
        check("rb2_next_pc", 32'(next_pc), 'h0100);
        @(negedge clk);
        reset       = 1'b0;
        instr_ready = 1'b0;
        #1;
        check("rb2_boot_pc",      32'(pc), 'h0100);
        check("rb2_boot_valid",   32'(instr_valid), 0);
        check("rb2_boot_mem_rd",  32'(mem_rd), 0);
        check("rb2_boot_next_pc", 32'(next_pc), 'h0100);
        check("rb2_boot_len",     32'(instr_len), 0);
        check("rb2_boot_opcode",  32'(instr_opcode), 0);
        @(negedge clk);
        #1;
        check("rb2_fetch_addr", 32'(mem_addr), 'h0100);
        check("rb2_fetch_rd",   32'(mem_rd), 1);

        check("sb_final_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of program_counter. Reads variable-length instructions (1–3 bytes) from 8-bit program memory at the current pc.
- Presents each complete instruction to the decoder over a valid/ready handshake.
- Produces the next_pc value that program_counter loads on every clk edge: hold, sequential advance, branch target, or reset vector.

Parameters:
- RESET_VECTOR, 16'h0000, address loaded into program_counter on the first cycle after reset.
- ADDR_W, 16, pc/next_pc/memory address width.

Ports:
- clk  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high reset
- pc  in  ADDR_W  current program_counter output
- next_pc  out  ADDR_W  value program_counter loads next edge
- mem_addr  out  ADDR_W  program memory byte address
- mem_rd  out  1  read request, held until mem_ready
- mem_rdata  in  8  read data, valid when mem_ready=1
- mem_ready  in  1  read completes this cycle
- branch_taken  in  1  redirect request from execute (1-cycle pulse)
- branch_target  in  ADDR_W  redirect address
- instr_valid  out  1  instruction bundle valid
- instr_ready  in  1  decoder accepts bundle
- instr_opcode  out  8  byte 0
- instr_op1  out  8  byte 1 (0 if absent)
- instr_op2  out  8  byte 2 (0 if absent)
- instr_len  out  2  1, 2 or 3
- instr_pc  out  ADDR_W  address of byte 0

Behaviour:
- Length decode from opcode[7:6]: 00→1, 01→2, 10→3, 11→1.
- States: BOOT, FETCH_OP, FETCH_B1, FETCH_B2, ISSUE.
- While reset=1: state←BOOT; all bundle registers and instr_valid←0; mem_rd=0; next_pc=RESET_VECTOR.
- BOOT (one cycle): next_pc=RESET_VECTOR, mem_rd=0 → FETCH_OP. Guarantees pc=RESET_VECTOR regardless of program_counter's own reset value.
- Default next_pc=pc (hold) in every state unless stated otherwise.
- mem_addr=pc+byte_idx (0/1/2 for FETCH_OP/B1/B2), 16-bit wrap (16'hFFFF+1=16'h0000). mem_rd=1 in FETCH_* states.
- FETCH_OP with mem_ready: latch opcode, instr_pc←pc, clear op1/op2. Go to ISSUE if len=1, else FETCH_B1.
- FETCH_B1 with mem_ready: latch op1. Go to ISSUE if len=2, else FETCH_B2.
- FETCH_B2 with mem_ready: latch op2 → ISSUE.
- Without mem_ready, a FETCH_* state holds, with mem_addr and mem_rd stable. Memory latency is arbitrary (≥0 wait cycles).
- ISSUE: instr_valid=1, bundle stable until accepted.
  - On instr_valid&&instr_ready: next_pc=pc+instr_len (wrap mod 2^16) → FETCH_OP.
  - Otherwise hold.
- Throughput: a 1-byte instruction with zero-wait memory and instr_ready=1 takes 2 cycles (FETCH_OP, ISSUE).
- branch_taken (highest priority below reset), in any state except BOOT:
  - next_pc=branch_target; state→FETCH_OP.
  - instr_valid is forced 0 combinationally that cycle, so no handshake occurs.
  - Any partially fetched bundle is discarded.
  - mem_rd may drop mid-request; memory tolerates abandoned reads.
- branch_taken during BOOT is ignored.
- Reset asserted mid-fetch or mid-ISSUE aborts immediately per reset rule.
- instr_len reset value 0; op bytes not yet fetched read 0.

Test Plan:
- Boot: reset 2 cycles, RESET_VECTOR=16'h0100 → next_pc=16'h0100 in BOOT cycle; pc=16'h0100; first mem_addr=16'h0100.
- Sequence, zero-wait memory, instr_ready=1, mem bytes at 0x0100: 0x05 / 0x45,0xAA / 0x85,0x34,0x12.
  - Bundles in order: (05,len1,pc 0100), (45,AA,len2,pc 0101), (85,34,12,len3,pc 0103).
  - pc then 16'h0106.
- Backpressure: instr_ready=0 for 4 cycles in ISSUE → instr_valid stays 1, bundle unchanged, next_pc=pc throughout; accept → pc advances by len exactly once.
- Wait states: mem_ready low 3 cycles per byte on 3-byte opcode 0x80 → mem_addr/mem_rd stable while waiting; bundle issued after 12 cycles; next_pc=pc+3.
- Branch: branch_taken with target 16'h2000 during FETCH_B1, and again during ISSUE with instr_ready=1 → no handshake, next_pc=16'h2000, next mem_addr=16'h2000, old bytes discarded.
- Wrap / reset: 2-byte opcode at 16'hFFFF → operand read at 16'h0000, next_pc=16'h0001. Reset asserted while in FETCH_B2 → instr_valid=0, state BOOT, pc=RESET_VECTOR.
